// File: rtl/uart_rx_os.sv
// Oversampling (16x) UART receiver: start-bit centring, LSB-first data, stop check.
// Build option: define UART_RX_PARITY_EN to receive an even-parity bit before the stop bit.
module uart_rx_os #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int SW = $clog2(SB_TICK);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t          state_q;
    logic [1:0]      sync_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] shift_q;

    logic            rx_s;
    logic [SW-1:0]   s_d;
    logic [NW-1:0]   n_d;
    logic [DBIT-1:0] shift_d;

    assign rx_s    = sync_q[1];
    assign s_d     = s_q + SW'(1);
    assign n_d     = n_q + NW'(1);
    assign shift_d = {rx_s, shift_q[DBIT-1:1]};

`ifdef UART_RX_PARITY_EN
    logic par_bit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit_q  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state_q == PARITY && s_tick && s_q == S_LAST) begin
                par_bit_q <= rx_s;
            end
            // Even parity: data bits plus parity bit must XOR to zero.
            if (state_q == STOP && s_tick && s_q == S_STOP) begin
                parity_err <= (^shift_q) ^ par_bit_q;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Receive FSM; every decision uses the synchronised line, and only the
    // IDLE exit may happen on a cycle without a sample tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            s_q          <= '0;
            n_q          <= '0;
            shift_q      <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx};
            rx_done_tick <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        s_q     <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_q == S_MID) begin
                            if (!rx_s) begin
                                s_q     <= '0;
                                n_q     <= '0;
                                state_q <= DATA;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_d;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_q == S_LAST) begin
                            s_q     <= '0;
                            shift_q <= shift_d;
                            if (n_q == N_LAST) begin
                                state_q <= AFTER_DATA;
                            end else begin
                                n_q <= n_d;
                            end
                        end else begin
                            s_q <= s_d;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s_q == S_LAST) begin
                            s_q     <= '0;
                            state_q <= STOP;
                        end else begin
                            s_q <= s_d;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (s_q == S_STOP) begin
                            dout         <= shift_q;
                            frame_err    <= ~rx_s;
                            rx_done_tick <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            s_q <= s_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are driven bit by bit, strobes logged by a monitor.
// Parity scenarios are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int passed = 0;
    int cycle = 0;
    int tickDiv = 1;
    int tickCnt = 0;
    int startCycle = 0;
    int doneCycle = 0;
    int doneCount = 0;
    logic [7:0] doneDout[$];
    logic       doneFerr[$];
    logic       donePerr[$];

`ifdef UART_RX_PARITY_EN
    bit flipParity = 1'b0;
    localparam int EXTRA_BITS = 1;
`else
    localparam int EXTRA_BITS = 0;
`endif

    uart_rx_os #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Tick generator: one-clk pulse every tickDiv clocks, changed on the falling edge.
    always @(negedge clk) begin
        if (tickCnt >= tickDiv - 1) begin
            tickCnt = 0;
            s_tick  = 1'b1;
        end else begin
            tickCnt++;
            s_tick = 1'b0;
        end
    end

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            doneDout.push_back(dout);
            doneFerr.push_back(frame_err);
            donePerr.push_back(parity_err);
            doneCycle = cycle;
            doneCount++;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic holdBit(input logic val);
        rx = val;
        repeat (16 * tickDiv) @(negedge clk);
    endtask

    task automatic idleBits(input int nBits);
        rx = 1'b1;
        repeat (16 * tickDiv * nBits) @(negedge clk);
    endtask

    // Called on a falling edge; returns on a falling edge right after the stop bit.
    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        startCycle = cycle;
        holdBit(1'b0);
        for (int i = 0; i < 8; i++) holdBit(data[i]);
`ifdef UART_RX_PARITY_EN
        holdBit((^data) ^ flipParity);
`endif
        holdBit(stopBit);
        rx = 1'b1;
    endtask

    task automatic waitDone(input int target);
        for (int i = 0; i < 3000 && doneCount < target; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (dout !== 8'h00) $display("[TB] FAIL reset_dout got %h want 00", dout); else passed++;
        checks++; if (rx_done_tick !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", rx_done_tick); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_ferr got %b want 0", frame_err); else passed++;
        checks++; if (parity_err !== 1'b0) $display("[TB] FAIL reset_perr got %b want 0", parity_err); else passed++;
    endtask

    task automatic test_basic();
        int base;
        int lat;
        base = doneCount;
        sendFrame(8'hA5, 1'b1);
        waitDone(base + 1);
        idleBits(1);
        lat = doneCycle - startCycle;
        checks++; if (doneCount !== base + 1) $display("[TB] FAIL basic_count got %0d want %0d", doneCount, base + 1); else passed++;
        checks++; if (dout !== 8'hA5) $display("[TB] FAIL basic_dout got %h want a5", dout); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL basic_ferr got %b want 0", frame_err); else passed++;
        checks++; if (parity_err !== 1'b0) $display("[TB] FAIL basic_perr got %b want 0", parity_err); else passed++;
        checks++;
        if (lat < 154 + 16 * EXTRA_BITS || lat > 156 + 16 * EXTRA_BITS)
            $display("[TB] FAIL basic_latency got %0d want %0d", lat, 155 + 16 * EXTRA_BITS);
        else passed++;
    endtask

    task automatic test_glitch();
        int base;
        base = doneCount;
        rx = 1'b0;
        repeat (4 * tickDiv) @(negedge clk);
        idleBits(3);
        checks++; if (doneCount !== base) $display("[TB] FAIL glitch_count got %0d want %0d", doneCount, base); else passed++;
        checks++; if (dout !== 8'hA5) $display("[TB] FAIL glitch_dout got %h want a5", dout); else passed++;
    endtask

    task automatic test_frame_error();
        int base;
        base = doneCount;
        sendFrame(8'h3C, 1'b0);
        waitDone(base + 1);
        idleBits(3);
        checks++; if (doneCount !== base + 1) $display("[TB] FAIL ferr_count got %0d want %0d", doneCount, base + 1); else passed++;
        checks++; if (dout !== 8'h3C) $display("[TB] FAIL ferr_dout got %h want 3c", dout); else passed++;
        checks++; if (frame_err !== 1'b1) $display("[TB] FAIL ferr_flag got %b want 1", frame_err); else passed++;
        sendFrame(8'h55, 1'b1);
        waitDone(base + 2);
        idleBits(2);
        checks++; if (doneCount !== base + 2) $display("[TB] FAIL ferr_next_count got %0d want %0d", doneCount, base + 2); else passed++;
        checks++; if (dout !== 8'h55) $display("[TB] FAIL ferr_next_dout got %h want 55", dout); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL ferr_next_flag got %b want 0", frame_err); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int base;
        base = doneCount;
        holdBit(1'b0);
        for (int i = 0; i < 4; i++) holdBit(1'b1);
        rx = 1'b1;
        repeat (8 * tickDiv) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (dout !== 8'h00) $display("[TB] FAIL midrst_dout got %h want 00", dout); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL midrst_ferr got %b want 0", frame_err); else passed++;
        idleBits(12);
        checks++; if (doneCount !== base) $display("[TB] FAIL midrst_count got %0d want %0d", doneCount, base); else passed++;
        sendFrame(8'h12, 1'b1);
        waitDone(base + 1);
        idleBits(2);
        checks++; if (doneCount !== base + 1) $display("[TB] FAIL midrst_next_count got %0d want %0d", doneCount, base + 1); else passed++;
        checks++; if (dout !== 8'h12) $display("[TB] FAIL midrst_next_dout got %h want 12", dout); else passed++;
    endtask

    task automatic test_back_to_back();
        int base;
        tickDiv = 3;
        idleBits(2);
        base = doneCount;
        sendFrame(8'h00, 1'b1);
        sendFrame(8'hFF, 1'b1);
        waitDone(base + 2);
        idleBits(2);
        checks++; if (doneCount !== base + 2) $display("[TB] FAIL b2b_count got %0d want %0d", doneCount, base + 2); else passed++;
        if (doneCount >= base + 2) begin
            checks++; if (doneDout[base] !== 8'h00) $display("[TB] FAIL b2b_first got %h want 00", doneDout[base]); else passed++;
            checks++; if (doneDout[base+1] !== 8'hFF) $display("[TB] FAIL b2b_second got %h want ff", doneDout[base+1]); else passed++;
            checks++; if (doneFerr[base+1] !== 1'b0) $display("[TB] FAIL b2b_ferr got %b want 0", doneFerr[base+1]); else passed++;
        end else begin
            checks++;
            $display("[TB] FAIL b2b_log got %0d pulses want %0d", doneCount - base, 2);
        end
        tickDiv = 1;
        idleBits(1);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int base;
        base = doneCount;
        flipParity = 1'b0;
        sendFrame(8'h07, 1'b1);
        waitDone(base + 1);
        idleBits(2);
        checks++; if (dout !== 8'h07) $display("[TB] FAIL par_good_dout got %h want 07", dout); else passed++;
        checks++; if (parity_err !== 1'b0) $display("[TB] FAIL par_good_perr got %b want 0", parity_err); else passed++;
        flipParity = 1'b1;
        sendFrame(8'h07, 1'b1);
        waitDone(base + 2);
        idleBits(2);
        flipParity = 1'b0;
        checks++; if (doneCount !== base + 2) $display("[TB] FAIL par_count got %0d want %0d", doneCount, base + 2); else passed++;
        checks++; if (dout !== 8'h07) $display("[TB] FAIL par_bad_dout got %h want 07", dout); else passed++;
        checks++; if (parity_err !== 1'b1) $display("[TB] FAIL par_bad_perr got %b want 1", parity_err); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL par_bad_ferr got %b want 0", frame_err); else passed++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        idleBits(1);
        test_basic();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
